// File: rtl/tap_multi_user_if.sv
// -----------------------------------------------------------------------------
// tap_multi_user_if
//
// Purpose
//   Bundles the four serial JTAG pins of the multi-user TAP so that the test
//   access port moves as one object between the TAP and whoever drives it
//   (a board-level probe model, a bench, or a chip-level pad ring).
//
// Signals
//   tms     probe -> TAP  test mode select, sampled on the rising edge of tck
//   tdi     probe -> TAP  serial data in, sampled on the rising edge of tck
//   tdo     TAP -> probe  serial data out, combinational from the selected
//                         shift register's bit 0
//   tdo_en  TAP -> probe  high only while the TAP is in Shift-DR or Shift-IR
//
// Transfer semantics
//   There is no valid/ready pair on a JTAG port: every rising edge of tck is
//   one transfer. The probe presents tms/tdi before the edge and reads tdo
//   before the same edge; tdo is only meaningful while tdo_en is high.
//
// Modports
//   master  the probe side (drives tms/tdi, observes tdo/tdo_en)
//   slave   the TAP side   (observes tms/tdi, drives tdo/tdo_en)
// -----------------------------------------------------------------------------
interface tap_multi_user_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    modport master (
        output tms,
        output tdi,
        input  tdo,
        input  tdo_en
    );

    modport slave (
        input  tms,
        input  tdi,
        output tdo,
        output tdo_en
    );
endinterface

// File: rtl/tap_multi_user.sv
// -----------------------------------------------------------------------------
// tap_multi_user
//
// Purpose
//   IEEE 1149.1 TAP controller with an IR of IR_LEN bits, a 32-bit IDCODE
//   register, a 1-bit BYPASS register and NUM_CH independent user data
//   registers of DR_WIDTH bits each. Each user channel captures a parallel
//   word from the logic side at Capture-DR and hands the shifted-in word back
//   through a holding update register plus a one-cycle strobe.
//
// Ports
//   tck           sole clock, every flop updates on its rising edge
//   reset         synchronous, active-low reset
//   jtag          serial pins (tms, tdi in; tdo, tdo_en out), slave side
//   user_capture  channel k parallel capture data at [k*DR_WIDTH +: DR_WIDTH]
//   user_update   channel k update register at [k*DR_WIDTH +: DR_WIDTH]
//   user_strobe   bit k pulses for one cycle when channel k's update
//                 register is written
//   ir_value      currently latched instruction
//   tstate        current TAP state (also the debug view of the FSM)
//
// Instruction decode
//   INSTR_IDCODE         -> IDCODE register
//   INSTR_USER0 + k      -> user channel k (k < NUM_CH)
//   anything else        -> BYPASS (includes the all-ones code)
//
// Assumptions: IR_LEN >= 2, DR_WIDTH >= 2, 1 <= NUM_CH <= 8, bit 0 of
// IDCODE_VAL is 1, and INSTR_USER0 + NUM_CH - 1 stays below all-ones.
// -----------------------------------------------------------------------------
module tap_multi_user #(
    parameter int                  IR_LEN       = 4,
    parameter int                  NUM_CH       = 2,
    parameter int                  DR_WIDTH     = 8,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1A2B_3C4D,
    parameter int                  INSTR_IDCODE = 1,
    parameter int                  INSTR_USER0  = 8,
    parameter logic [DR_WIDTH-1:0] UPDATE_RST   = '0
) (
    input  logic                         tck,
    input  logic                         reset,
    tap_multi_user_if.slave              jtag,
    input  logic [NUM_CH*DR_WIDTH-1:0]   user_capture,
    output logic [NUM_CH*DR_WIDTH-1:0]   user_update,
    output logic [NUM_CH-1:0]            user_strobe,
    output logic [IR_LEN-1:0]            ir_value,
    output logic [3:0]                   tstate
);

    // -------------------------------------------------------------------------
    // TAP state encoding (standard 1149.1 values)
    // -------------------------------------------------------------------------
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    localparam logic [IR_LEN-1:0] IR_CODE_IDCODE = IR_LEN'(INSTR_IDCODE);
    // Capture-IR pattern: the two LSBs are 01, the rest zero.
    localparam logic [IR_LEN-1:0] IR_CAPTURE     = IR_LEN'(1);

    tap_state_t state_q;
    tap_state_t state_d;

    // Shift registers
    logic [IR_LEN-1:0]   ir_sr;
    logic [31:0]         id_sr;
    logic                byp_sr;
    logic [DR_WIDTH-1:0] user_sr [NUM_CH];

    // Decode of the latched instruction
    logic                sel_idcode;
    logic [NUM_CH-1:0]   user_oh;
    logic                sel_user;

    logic                tdo_bit;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge tck) begin
        if (!reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. Five tms=1 edges reach TLR from any state because
    // every state's tms=1 arc moves one step closer along the Select-IR path.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = jtag.tms ? TLR      : RTI;
            RTI:      state_d = jtag.tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = jtag.tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = jtag.tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = jtag.tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = jtag.tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = jtag.tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = jtag.tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = jtag.tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = jtag.tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = jtag.tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = jtag.tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = jtag.tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = jtag.tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = jtag.tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = jtag.tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    assign tstate = state_q;

    // -------------------------------------------------------------------------
    // Instruction decode. IDCODE wins if a user code ever aliases it, so at
    // most one data register is selected at any time.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_idcode = (ir_value == IR_CODE_IDCODE);
        user_oh    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!sel_idcode && (ir_value == IR_LEN'(INSTR_USER0 + k))) begin
                user_oh[k] = 1'b1;
            end
        end
    end

    assign sel_user = |user_oh;

    // -------------------------------------------------------------------------
    // Instruction register. ir_value changes only at the edge leaving
    // Update-IR (or is forced while in TLR), so a DR scan that is already
    // running always sees the previously latched instruction.
    // -------------------------------------------------------------------------
    always_ff @(posedge tck) begin
        if (!reset) begin
            ir_sr    <= '0;
            ir_value <= IR_CODE_IDCODE;
        end else begin
            case (state_q)
                TLR:     ir_value <= IR_CODE_IDCODE;
                CAP_IR:  ir_sr    <= IR_CAPTURE;
                SH_IR:   ir_sr    <= {jtag.tdi, ir_sr[IR_LEN-1:1]};
                UPD_IR:  ir_value <= ir_sr;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Data registers. Only the selected register captures or shifts; the
    // others hold. Pause/Exit states fall to the default arm, so shift
    // contents survive a pause untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge tck) begin
        if (!reset) begin
            id_sr  <= '0;
            byp_sr <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                user_sr[k] <= '0;
            end
        end else begin
            case (state_q)
                CAP_DR: begin
                    if (sel_idcode) begin
                        id_sr <= IDCODE_VAL;
                    end else if (sel_user) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (user_oh[k]) begin
                                user_sr[k] <= user_capture[k*DR_WIDTH +: DR_WIDTH];
                            end
                        end
                    end else begin
                        byp_sr <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_idcode) begin
                        id_sr <= {jtag.tdi, id_sr[31:1]};
                    end else if (sel_user) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (user_oh[k]) begin
                                user_sr[k] <= {jtag.tdi, user_sr[k][DR_WIDTH-1:1]};
                            end
                        end
                    end else begin
                        byp_sr <= jtag.tdi;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Update registers and strobe. Written on the edge that leaves Update-DR;
    // the strobe is cleared every other edge so it is exactly one cycle wide.
    // TLR deliberately leaves user_update alone; only reset restores it.
    // -------------------------------------------------------------------------
    always_ff @(posedge tck) begin
        if (!reset) begin
            user_update <= {NUM_CH{UPDATE_RST}};
            user_strobe <= '0;
        end else begin
            user_strobe <= '0;
            if (state_q == UPD_DR) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (user_oh[k]) begin
                        user_update[k*DR_WIDTH +: DR_WIDTH] <= user_sr[k];
                        user_strobe[k]                      <= 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Serial output. Combinational from bit 0 of the active shift register so
    // the first captured bit is visible during the first Shift cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        tdo_bit = 1'b0;
        if (state_q == SH_IR) begin
            tdo_bit = ir_sr[0];
        end else if (state_q == SH_DR) begin
            if (sel_idcode) begin
                tdo_bit = id_sr[0];
            end else if (sel_user) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (user_oh[k]) begin
                        tdo_bit = user_sr[k][0];
                    end
                end
            end else begin
                tdo_bit = byp_sr;
            end
        end
    end

    assign jtag.tdo    = tdo_bit;
    assign jtag.tdo_en = (state_q == SH_DR) || (state_q == SH_IR);

endmodule
